// File: rtl/prefix_tracker.sv
// Instruction-prefix tracker: holds segment override, REP/REPNE and LOCK since the
// last instruction boundary, drives the effective segment select, counts prefixes.
module prefix_tracker #(
  parameter int SR_WIDTH     = 2,
  parameter int SS_INDEX     = 2,
  parameter int MAX_PREFIXES = 15,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                next_instruction,
  input  logic                prefix_valid,
  input  logic [1:0]          prefix_kind,
  input  logic [SR_WIDTH-1:0] prefix_sr,
  input  logic                force_segment,
  input  logic                bp_is_base,
  input  logic [SR_WIDTH-1:0] microcode_sr_rd_sel,
  output logic [SR_WIDTH-1:0] sr_rd_sel,
  output logic                override_active,
  output logic                rep_active,
  output logic                rep_is_repne,
  output logic                lock_active,
  output logic [CNT_WIDTH-1:0] prefix_count,
  output logic                prefix_overflow
);

  typedef enum logic [1:0] {
    K_SEG   = 2'd0,
    K_REP   = 2'd1,
    K_REPNE = 2'd2,
    K_LOCK  = 2'd3
  } kind_t;

  typedef struct packed {
    logic [SR_WIDTH-1:0]  ovr;
    logic                 ovr_act;
    logic                 rep;
    logic                 repne;
    logic                 lock;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf;
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_PREFIXES);
  localparam logic [SR_WIDTH-1:0]  SS_SEL  = SR_WIDTH'(SS_INDEX);

  state_t st_q, st_d, held;
  kind_t  kind;

  assign kind = kind_t'(prefix_kind);

  always_comb begin
    // A boundary wipes everything first; a prefix in the same cycle then lands on
    // the clean slate as the first prefix of the new instruction.
    held = next_instruction ? '0 : st_q;
    st_d = held;
    st_d.ovf = 1'b0;
    if (prefix_valid) begin
      case (kind)
        K_SEG: begin
          st_d.ovr     = prefix_sr;
          st_d.ovr_act = 1'b1;
        end
        K_REP: begin
          st_d.rep   = 1'b1;
          st_d.repne = 1'b0;
        end
        K_REPNE: begin
          st_d.rep   = 1'b1;
          st_d.repne = 1'b1;
        end
        default: st_d.lock = 1'b1;
      endcase
      if (held.cnt == CNT_MAX) begin
        st_d.cnt = CNT_MAX;
        st_d.ovf = 1'b1;
      end else begin
        st_d.cnt = held.cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= '0;
    else          st_q <= st_d;
  end

  // Selection uses registered state only, so a fresh SEG prefix has no bypass.
  always_comb begin
    if (force_segment)      sr_rd_sel = microcode_sr_rd_sel;
    else if (st_q.ovr_act)  sr_rd_sel = st_q.ovr;
    else if (bp_is_base)    sr_rd_sel = SS_SEL;
    else                    sr_rd_sel = microcode_sr_rd_sel;
  end

  assign override_active = st_q.ovr_act;
  assign rep_active      = st_q.rep;
  assign rep_is_repne    = st_q.repne;
  assign lock_active     = st_q.lock;
  assign prefix_count    = st_q.cnt;
  assign prefix_overflow = st_q.ovf;

endmodule

// File: tb/tb_prefix_tracker.sv
// Bench for prefix_tracker: directed scenarios plus randomized traffic against a
// rule-level model; a second instance covers SR_WIDTH=3 / SS_INDEX=5.
module tb_prefix_tracker;
  localparam int MAXP = 15;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       ni, pv, fs, bp;
  logic [1:0] pk, psr, mc;
  logic [1:0] sel;
  logic       oa, ra, rn, la, ovf;
  logic [3:0] cnt;

  logic       w_ni, w_pv, w_fs, w_bp;
  logic [1:0] w_pk;
  logic [2:0] w_psr, w_mc, w_sel;
  logic       w_oa, w_ra, w_rn, w_la, w_ovf;
  logic [3:0] w_cnt;

  prefix_tracker dut (
    .clk(clk), .reset_n(reset_n), .next_instruction(ni), .prefix_valid(pv),
    .prefix_kind(pk), .prefix_sr(psr), .force_segment(fs), .bp_is_base(bp),
    .microcode_sr_rd_sel(mc), .sr_rd_sel(sel), .override_active(oa),
    .rep_active(ra), .rep_is_repne(rn), .lock_active(la),
    .prefix_count(cnt), .prefix_overflow(ovf)
  );

  prefix_tracker #(.SR_WIDTH(3), .SS_INDEX(5)) dut_w (
    .clk(clk), .reset_n(reset_n), .next_instruction(w_ni), .prefix_valid(w_pv),
    .prefix_kind(w_pk), .prefix_sr(w_psr), .force_segment(w_fs), .bp_is_base(w_bp),
    .microcode_sr_rd_sel(w_mc), .sr_rd_sel(w_sel), .override_active(w_oa),
    .rep_active(w_ra), .rep_is_repne(w_rn), .lock_active(w_la),
    .prefix_count(w_cnt), .prefix_overflow(w_ovf)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: what the prefix history since the boundary implies.
  logic [1:0] m_ovr;
  logic       m_oa, m_ra, m_rn, m_la, m_ovf;
  int         m_cnt;

  task automatic model_reset();
    m_ovr = '0; m_oa = 0; m_ra = 0; m_rn = 0; m_la = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic idle();
    ni = 0; pv = 0; pk = 0; psr = 0; fs = 0; bp = 0; mc = 0;
  endtask

  // One rising edge; the model consumes the inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    m_ovf = 0;
    if (ni) begin
      m_ovr = '0; m_oa = 0; m_ra = 0; m_rn = 0; m_la = 0; m_cnt = 0;
    end
    if (pv) begin
      if (m_cnt == MAXP) m_ovf = 1;
      m_cnt = (m_cnt < MAXP) ? m_cnt + 1 : MAXP;
      case (pk)
        2'd0: begin m_ovr = psr; m_oa = 1; end
        2'd1: begin m_ra = 1; m_rn = 0; end
        2'd2: begin m_ra = 1; m_rn = 1; end
        default: m_la = 1;
      endcase
    end
    #1;
  endtask

  function automatic logic [1:0] exp_sel();
    if (fs) return mc;
    if (m_oa) return m_ovr;
    if (bp) return 2'd2;
    return mc;
  endfunction

  function automatic logic [8:0] exp_state();
    return {m_oa, m_ra, m_rn, m_la, 4'(m_cnt), m_ovf};
  endfunction

  function automatic logic [8:0] act_state();
    return {oa, ra, rn, la, cnt, ovf};
  endfunction

  task automatic test_reset();
    idle();
    w_ni = 0; w_pv = 0; w_pk = 0; w_psr = 0; w_fs = 0; w_bp = 0; w_mc = 0;
    reset_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (act_state() !== 9'd0) begin
      mismatched++; $display("FAIL reset_state got=%b want=%b", act_state(), 9'd0);
    end
    @(negedge clk);
    reset_n = 1;
    bp = 1; mc = 3; #1;
    compared++;
    if (sel !== 2'd2) begin
      mismatched++; $display("FAIL reset_bp_sel got=%0d want=2", sel);
    end
    fs = 1; #1;
    compared++;
    if (sel !== 2'd3) begin
      mismatched++; $display("FAIL reset_force_sel got=%0d want=3", sel);
    end
    idle();
  endtask

  task automatic test_seg_override();
    pv = 1; pk = 0; psr = 0; tick();
    psr = 1; tick();
    pv = 0; bp = 1; mc = 0; #1;
    compared++;
    if (sel !== 2'd1 || cnt !== 4'd2) begin
      mismatched++; $display("FAIL seg_last_wins sel=%0d cnt=%0d want sel=1 cnt=2", sel, cnt);
    end
    compared++;
    if (act_state() !== exp_state()) begin
      mismatched++; $display("FAIL seg_state got=%b want=%b", act_state(), exp_state());
    end
    ni = 1; tick();
    ni = 0; #1;
    compared++;
    if (sel !== 2'd2 || oa !== 1'b0 || cnt !== 4'd0) begin
      mismatched++; $display("FAIL seg_boundary sel=%0d oa=%b cnt=%0d want 2/0/0", sel, oa, cnt);
    end
    idle();
  endtask

  task automatic test_rep_lock();
    pv = 1; pk = 1; tick();
    pk = 3; tick();
    pk = 2; tick();
    pv = 0; #1;
    compared++;
    if ({ra, rn, la, cnt} !== {1'b1, 1'b1, 1'b1, 4'd3}) begin
      mismatched++; $display("FAIL rep_lock_held got=%b%b%b cnt=%0d want 111 cnt=3", ra, rn, la, cnt);
    end
    ni = 1; pv = 1; pk = 0; psr = 3; tick();
    ni = 0; pv = 0; #1;
    compared++;
    if (act_state() !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0} || sel !== 2'd3) begin
      mismatched++; $display("FAIL boundary_with_prefix state=%b sel=%0d want 100000010 sel=3", act_state(), sel);
    end
    idle();
  endtask

  task automatic test_saturation();
    logic [1:0] last;
    last = 0;
    ni = 1; tick(); ni = 0;
    for (int i = 0; i < 16; i++) begin
      pv = 1; pk = 0; psr = 2'($urandom_range(0, 3)); last = psr;
      tick();
      compared++;
      if (ovf !== (i == 15) || cnt !== 4'((i + 1 < MAXP) ? i + 1 : MAXP)) begin
        mismatched++; $display("FAIL sat_step%0d ovf=%b cnt=%0d want ovf=%b cnt=%0d",
                               i, ovf, cnt, (i == 15), (i + 1 < MAXP) ? i + 1 : MAXP);
      end
    end
    pv = 0; tick();
    compared++;
    if (ovf !== 1'b0 || cnt !== 4'd15 || sel !== last) begin
      mismatched++; $display("FAIL sat_hold ovf=%b cnt=%0d sel=%0d want 0/15/%0d", ovf, cnt, sel, last);
    end
    idle();
  endtask

  task automatic test_async_reset();
    ni = 1; tick(); ni = 0;
    pv = 1; pk = 0; psr = 2;
    repeat (5) tick();
    pv = 0; mc = 1; #1;
    compared++;
    if (oa !== 1'b1 || cnt !== 4'd5) begin
      mismatched++; $display("FAIL pre_reset oa=%b cnt=%0d want 1/5", oa, cnt);
    end
    #2 reset_n = 0;
    #1;
    model_reset();
    compared++;
    if (act_state() !== 9'd0 || sel !== 2'd1) begin
      mismatched++; $display("FAIL async_reset state=%b sel=%0d want 0 sel=1", act_state(), sel);
    end
    @(negedge clk);
    reset_n = 1;
    pv = 1; pk = 3; tick();
    pv = 0;
    compared++;
    if (act_state() !== exp_state()) begin
      mismatched++; $display("FAIL post_reset state=%b want=%b", act_state(), exp_state());
    end
    idle();
  endtask

  task automatic test_wide_params();
    w_bp = 1; w_mc = 1; #1;
    compared++;
    if (w_sel !== 3'd5) begin
      mismatched++; $display("FAIL wide_ss got=%0d want=5", w_sel);
    end
    w_pv = 1; w_pk = 0; w_psr = 6; tick();
    w_pv = 0; #1;
    compared++;
    if (w_sel !== 3'd6 || w_oa !== 1'b1 || w_cnt !== 4'd1) begin
      mismatched++; $display("FAIL wide_override sel=%0d oa=%b cnt=%0d want 6/1/1", w_sel, w_oa, w_cnt);
    end
    w_ni = 1; tick(); w_ni = 0; #1;
    compared++;
    if (w_sel !== 3'd5 || w_oa !== 1'b0) begin
      mismatched++; $display("FAIL wide_clear sel=%0d oa=%b want 5/0", w_sel, w_oa);
    end
    w_bp = 0; w_mc = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ni  = ($urandom_range(0, 23) == 0);
      pv  = ($urandom_range(0, 3) != 0);
      pk  = 2'($urandom_range(0, 3));
      psr = 2'($urandom_range(0, 3));
      fs  = ($urandom_range(0, 3) == 0);
      bp  = 1'($urandom_range(0, 1));
      mc  = 2'($urandom_range(0, 3));
      #1;
      compared++;
      if (sel !== exp_sel()) begin
        mismatched++; $display("FAIL rand_sel cyc=%0d got=%0d want=%0d", i, sel, exp_sel());
      end
      tick();
      compared++;
      if (act_state() !== exp_state()) begin
        mismatched++; $display("FAIL rand_state cyc=%0d got=%b want=%b", i, act_state(), exp_state());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_seg_override();
    test_rep_lock();
    test_saturation();
    test_async_reset();
    test_wide_params();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
